usb_in_ep_scheduler: RTL
========================

# usb_in_ep_scheduler

Packetising scheduler that shares one USB IN endpoint between two byte-stream producers (e.g. two UART-style bridge channels). It arbitrates round-robin per packet, drives the endpoint req/grant/put/done handshake, and closes packets on a size limit or an idle timeout. It sits between the producer logic and the IN endpoint port of the USB device core.

## Interface
- `MAX_PKT`, 64: maximum data bytes per packet, 1..64.
- `FLUSH_CYCLES`, 1024: idle cycles without a byte before an open packet is closed, ≥2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset (asserted when 0).
- `ch0_valid` / `ch1_valid` in 1: producer has a byte.
- `ch0_data` / `ch1_data` in 8: producer byte.
- `ch0_ready` / `ch1_ready` out 1: byte accepted this cycle when valid && ready.
- `in_ep_req` out 1: endpoint request, held for the whole packet.
- `in_ep_grant` in 1: endpoint granted.
- `in_ep_data_free` in 1: endpoint buffer can take a byte.
- `in_ep_data_put` out 1: write `in_ep_data` this cycle.
- `in_ep_data` out 8: byte to endpoint.
- `in_ep_data_done` out 1: one-cycle pulse, packet complete.
- `in_ep_acked` in 1: host ACKed the packet.
- `in_ep_stall` out 1: tied 0.
- `busy` out 1: state ≠ IDLE.
- `active_ch` out 1: channel owning the current packet.

## Operation
- States: IDLE, REQ, HDR (only with header), DATA, DONE, ACK.
- IDLE: if any `chN_valid`, select a channel: only one valid → that one; both valid → the channel ≠ `last_ch`. Latch `active_ch`, set `last_ch`, go REQ. `last_ch` resets to 1, so ch0 wins the first tie.
- REQ: `in_ep_req`=1. When `in_ep_grant && in_ep_data_free` → HDR if enabled, else DATA. Clear `byte_cnt` and `idle_cnt`.
- HDR: when `in_ep_data_free`, put header byte 8'h80 | active_ch → DATA.
- DATA: `chN_ready` = (N == active_ch) && `in_ep_grant` && `in_ep_data_free`. Put = valid && ready. `in_ep_data` = selected channel data, pass-through. Each put increments `byte_cnt` (7 bits) and clears `idle_cnt`. Each cycle without a put increments `idle_cnt`.
- DATA exit to DONE:
  - The put that makes `byte_cnt` == MAX_PKT.
  - `idle_cnt` == FLUSH_CYCLES-1, including when `byte_cnt` == 0, which yields a zero-length or header-only packet.
- DONE: pulse `in_ep_data_done`, drop `in_ep_req` → ACK.
- ACK: wait for `in_ep_acked` → IDLE. Producers are not ready during ACK.
- The non-selected channel is never ready. At most one put per cycle.

## Timing
- Reset values: `in_ep_req`=0, `in_ep_data_put`=0, `in_ep_data_done`=0, `ch0_ready`=`ch1_ready`=0, `busy`=0, `active_ch`=0, `in_ep_data`=0 in IDLE, `in_ep_stall`=0.
- `in_ep_data_put` and `chN_ready` are combinational from state and endpoint inputs. The accepted byte is written to the endpoint in the same cycle (0 latency).
- First possible put is 2 cycles after `chN_valid` rises in IDLE with the grant already high: IDLE→REQ, REQ→DATA, put in DATA.
- `in_ep_data_done` rises the cycle after the last put or the timeout cycle, and lasts exactly 1 cycle.
- `in_ep_data_free` dropping mid-packet stalls the transfer only. The packet does not end, and `idle_cnt` keeps counting.
- If `in_ep_acked` arrives in the same cycle as DONE, it is ignored. Only acks seen in ACK count.
- Reset mid-packet: all outputs return to reset values on the next edge. No done pulse is issued, and the partial packet is abandoned.
- `byte_cnt` never exceeds MAX_PKT. `idle_cnt` saturates at FLUSH_CYCLES-1.

## Configuration
- `USB_IN_SCHED_HDR_EN` defined:
  - Every packet starts with header byte 8'h80 | active_ch.
  - The header does not count toward MAX_PKT.
  - Timeout with 0 data bytes sends a 1-byte header-only packet.
- Undefined: no HDR state, payload only, and a timeout with 0 bytes sends a zero-length packet.

## Structure
- Package `usb_in_sched_pkg`: state enum encoding, `HDR_TAG` = 8'h80, and the counter width `CNT_W` = 7.
- One sub-module, `rr_arb2`: the 2-way round-robin picker. It takes valids and `last_ch` and returns grant and index. Everything else stays in the top FSM.

## Test plan
- Single byte: ch0 sends 8'h48, grant and data_free held high → one put of 8'h48. Done pulses after FLUSH_CYCLES idle cycles. Ack returns to IDLE.
- Full packet: ch1 streams 70 bytes 0..69 with MAX_PKT=64 → first packet is bytes 0..63 with done the cycle after byte 63. After ack, a second packet carries 64..69.
- Fairness: both channels continuously valid → packets alternate ch0, ch1, ch0, and a channel never gets ready while not active.
- Backpressure: drop data_free for 5 cycles mid-packet → no puts and no ready in that window. The byte sequence is unchanged and the packet does not end early.
- Reset mid-packet: pull reset low after 10 puts → next cycle req=0, put=0, done never pulses, busy=0. A new packet then starts cleanly.
- With `USB_IN_SCHED_HDR_EN`: ch1 sends 8'h01,8'h02 → endpoint sees 8'h81, 8'h01, 8'h02. A timeout with no data yields the single byte 8'h80 or 8'h81.

Source files
------------

// File: rtl/usb_in_sched_pkg.sv
// Shared types and constants for the USB IN endpoint scheduler.
package usb_in_sched_pkg;

   localparam int         CNT_W   = 7;
   localparam logic [7:0] HDR_TAG = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_HDR  = 3'd2,
      ST_DATA = 3'd3,
      ST_DONE = 3'd4,
      ST_ACK  = 3'd5
   } state_t;

endpackage

// File: rtl/usb_in_ep_scheduler_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// channel that did not own the previous packet.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_ch,
   output logic       grant,
   output logic       idx
);

   // pick the winner combinationally
   always_comb begin
      grant = |valid;
      idx   = (&valid) ? ~last_ch : valid[1];
   end

endmodule

// File: rtl/usb_in_ep_scheduler.sv
// Packetising scheduler sharing one USB IN endpoint between two byte
// producers. Packets close on MAX_PKT bytes or FLUSH_CYCLES idle cycles.
// Optional macro USB_IN_SCHED_HDR_EN prefixes each packet with 8'h80|ch.
module usb_in_ep_scheduler
   import usb_in_sched_pkg::*;
#(
   parameter int MAX_PKT      = 64,
   parameter int FLUSH_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ch0_valid,
   input  logic [7:0] ch0_data,
   output logic       ch0_ready,
   input  logic       ch1_valid,
   input  logic [7:0] ch1_data,
   output logic       ch1_ready,
   output logic       in_ep_req,
   input  logic       in_ep_grant,
   input  logic       in_ep_data_free,
   output logic       in_ep_data_put,
   output logic [7:0] in_ep_data,
   output logic       in_ep_data_done,
   input  logic       in_ep_acked,
   output logic       in_ep_stall,
   output logic       busy,
   output logic       active_ch
);

   localparam int               IDLE_W   = $clog2(FLUSH_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_PKT - 1);

   state_t              state, state_nx;
   logic                last_ch, act;
   logic [CNT_W-1:0]    byte_cnt;
   logic [IDLE_W-1:0]   idle_cnt;
   logic                arb_gnt, arb_idx;
   logic                sel_valid;
   logic [7:0]          sel_data;
   logic                put;

   rr_arb2 u_arb (
      .valid   ({ch1_valid, ch0_valid}),
      .last_ch (last_ch),
      .grant   (arb_gnt),
      .idx     (arb_idx)
   );

   assign sel_valid   = act ? ch1_valid : ch0_valid;
   assign sel_data    = act ? ch1_data  : ch0_data;
   assign in_ep_stall = 1'b0;
   assign busy        = (state != ST_IDLE);
   assign active_ch   = act;

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // channel ownership and packet counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_ch  <= 1'b1;
         act      <= 1'b0;
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: if (arb_gnt) begin
               act     <= arb_idx;
               last_ch <= arb_idx;
            end
            ST_REQ: begin
               byte_cnt <= '0;
               idle_cnt <= '0;
            end
            ST_DATA: begin
               if (put) begin
                  byte_cnt <= byte_cnt + CNT_W'(1);
                  idle_cnt <= '0;
               end else if (idle_cnt != IDLE_MAX) begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // next-state: a packet ends on its last allowed byte or on a full idle window
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (arb_gnt) state_nx = ST_REQ;
         ST_REQ: if (in_ep_grant && in_ep_data_free) begin
`ifdef USB_IN_SCHED_HDR_EN
            state_nx = ST_HDR;
`else
            state_nx = ST_DATA;
`endif
         end
`ifdef USB_IN_SCHED_HDR_EN
         ST_HDR: if (in_ep_data_free) state_nx = ST_DATA;
`endif
         ST_DATA: begin
            if (put && byte_cnt == CNT_LAST)       state_nx = ST_DONE;
            else if (!put && idle_cnt == IDLE_MAX) state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_ACK;
         ST_ACK:  if (in_ep_acked) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // outputs: ready/put are pass-through so a byte lands in the same cycle
   always_comb begin
      in_ep_req       = 1'b0;
      in_ep_data_done = 1'b0;
      ch0_ready       = 1'b0;
      ch1_ready       = 1'b0;
      put             = 1'b0;
      in_ep_data      = 8'h00;
      case (state)
         ST_REQ: in_ep_req = 1'b1;
`ifdef USB_IN_SCHED_HDR_EN
         ST_HDR: begin
            in_ep_req  = 1'b1;
            put        = in_ep_data_free;
            in_ep_data = HDR_TAG | {7'b0, act};
         end
`endif
         ST_DATA: begin
            in_ep_req  = 1'b1;
            ch0_ready  = !act && in_ep_grant && in_ep_data_free;
            ch1_ready  =  act && in_ep_grant && in_ep_data_free;
            put        = sel_valid && in_ep_grant && in_ep_data_free;
            in_ep_data = sel_data;
         end
         ST_DONE: in_ep_data_done = 1'b1;
         default: ;
      endcase
      in_ep_data_put = put;
   end

endmodule
